linear_layer_srl_fifo_mc: RTL and testbench

LINEAR_LAYER_SRL_FIFO_MC -- requirements
Module: linear_layer_srl_fifo_mc

---
 rtl/linear_layer_srl_fifo_mc_pkg.sv | 14 +
 rtl/linear_layer_srl_fifo_mc_bank.sv | 36 +++
 rtl/linear_layer_srl_fifo_mc.sv | 97 +++++++++
 tb/tb_linear_layer_srl_fifo_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_srl_fifo_mc_pkg.sv
// Shared helpers for the multi-channel SRL FIFO.
//   count_width(depth) : bits needed to hold an occupancy of 0..depth
//   ch_lo(ch, w)       : low bit index of channel ch in a packed bus of w-bit lanes
package linear_layer_srl_fifo_mc_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ch_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_mc_bank.sv
// One channel of shift-register storage (DEPTH x DATA_WIDTH).
//   clk  : rising-edge clock
//   we   : shift enable; din enters slot 0 and every slot moves up by one
//   addr : read slot select (combinational read)
//   din  : word to shift in
//   dout : contents of slot addr
// Storage has no reset so it can map onto shift-register primitives.
module linear_layer_srl_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] slot_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      slot_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  // Decoded read keeps the index in range when DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_WIDTH'(i)) dout = slot_q[i];
  end

endmodule

// File: rtl/linear_layer_srl_fifo_mc.sv
// NUM_CH independent first-word-fall-through FIFOs on shift-register storage.
//   clk, reset        : clock, asynchronous active-high reset
//   if_write_ce/write : per-channel push enable/request, if_din packed per channel
//   if_full_n         : channel can accept a word (registered)
//   if_almost_full    : occupancy >= AF_THRESH (registered)
//   if_read_ce/read   : per-channel pop enable/request
//   if_dout           : head word per channel, valid while if_empty_n
//   if_empty_n        : channel holds at least one word (registered)
//   if_count          : per-channel occupancy, ADDR_WIDTH+1 bits each
// A push shifts storage, so the head sits at slot count-1; a pop only moves
// the read address down.
module linear_layer_srl_fifo_mc
  import linear_layer_srl_fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH-1:0]                if_write_ce,
  input  logic [NUM_CH-1:0]                if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     if_din,
  output logic [NUM_CH-1:0]                if_full_n,
  output logic [NUM_CH-1:0]                if_almost_full,
  input  logic [NUM_CH-1:0]                if_read_ce,
  input  logic [NUM_CH-1:0]                if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0]     if_dout,
  output logic [NUM_CH-1:0]                if_empty_n,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] if_count
);

  localparam int CW = ADDR_WIDTH + 1;

  if (count_width(DEPTH) > CW) begin : g_bad_depth
    $error("DEPTH does not fit in ADDR_WIDTH+1 count bits");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                  push, pop;
    logic [CW-1:0]         count_d, count_q;
    logic                  empty_n_d, empty_n_q;
    logic                  full_n_d, full_n_q;
    logic                  af_d, af_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] dout;

    always_comb begin
      push    = if_write_ce[c] & if_write[c] & full_n_q;
      pop     = if_read_ce[c] & if_read[c] & empty_n_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      // Flags follow the next-state count so they update with it.
      full_n_d  = (count_d != CW'(DEPTH));
      empty_n_d = (count_d != '0);
      af_d      = (int'(count_d) >= AF_THRESH);
      // Wraps when empty; dout is don't-care then.
      rd_addr   = ADDR_WIDTH'(count_q - 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q   <= '0;
        empty_n_q <= 1'b0;
        full_n_q  <= 1'b1;
        af_q      <= 1'b0;
      end else begin
        count_q   <= count_d;
        empty_n_q <= empty_n_d;
        full_n_q  <= full_n_d;
        af_q      <= af_d;
      end
    end

    linear_layer_srl_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (push),
      .addr (rd_addr),
      .din  (if_din[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
      .dout (dout)
    );

    assign if_dout[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH] = dout;
    assign if_count[ch_lo(c, CW) +: CW]                = count_q;
    assign if_empty_n[c]     = empty_n_q;
    assign if_full_n[c]      = full_n_q;
    assign if_almost_full[c] = af_q;
  end

endmodule

// File: tb/tb_linear_layer_srl_fifo_mc.sv
module tb_linear_layer_srl_fifo_mc;
  localparam int DW = 8, AW = 2, DEPTH = 4, NCH = 2, AF = DEPTH - 1;
  localparam int CW = AW + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NCH-1:0]     if_write_ce = '0, if_write = '0, if_read_ce = '0, if_read = '0;
  logic [NCH*DW-1:0]  if_din = '0;
  logic [NCH-1:0]     if_full_n, if_almost_full, if_empty_n;
  logic [NCH*DW-1:0]  if_dout;
  logic [NCH*CW-1:0]  if_count;

  linear_layer_srl_fifo_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(NCH), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_count(if_count)
  );

  always #5 clk = ~clk;

  // Reference: each channel is simply a queue of words in push order.
  logic [DW-1:0] mq    [NCH][$];
  // Scoreboard: words the monitor must see leave the DUT, in order.
  logic [DW-1:0] exp_q [NCH][$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] dout_of(input int c);
    return if_dout[c*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] count_of(input int c);
    return if_count[c*CW +: CW];
  endfunction

  // One cycle: check registered state against the model, drive inputs,
  // then advance the model by what the next rising edge should accept.
  task automatic step(input logic [NCH-1:0] wce, wr, rce, rd,
                      input logic [DW-1:0] d0, d1);
    logic [DW-1:0] d [NCH];
    d[0] = d0; d[1] = d1;
    @(negedge clk); #1;
    for (int c = 0; c < NCH; c++) begin
      int n = mq[c].size();
      chk($sformatf("count%0d", c),   32'(count_of(c)), 32'(n));
      chk($sformatf("empty_n%0d", c), 32'(if_empty_n[c]), 32'(n != 0));
      chk($sformatf("full_n%0d", c),  32'(if_full_n[c]), 32'(n != DEPTH));
      chk($sformatf("af%0d", c),      32'(if_almost_full[c]), 32'(n >= AF));
      if (n != 0) chk($sformatf("head%0d", c), 32'(dout_of(c)), 32'(mq[c][0]));
    end
    if_write_ce = wce; if_write = wr; if_read_ce = rce; if_read = rd;
    if_din = {d1, d0};
    for (int c = 0; c < NCH; c++) begin
      bit push_ok = wce[c] && wr[c] && (mq[c].size() != DEPTH);
      bit pop_ok  = rce[c] && rd[c] && (mq[c].size() != 0);
      if (pop_ok) exp_q[c].push_back(mq[c].pop_front());
      if (push_ok) mq[c].push_back(d[c]);
    end
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: whenever the DUT is about to hand out a word, compare with
  // the scoreboard.
  initial forever begin
    @(negedge clk); #4;
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (if_read_ce[c] && if_read[c] && if_empty_n[c]) begin
          if (exp_q[c].size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected ch%0d: got %0h expected none", c, dout_of(c));
          end else begin
            chk($sformatf("pop_data%0d", c), 32'(dout_of(c)), 32'(exp_q[c].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #12;
    for (int c = 0; c < NCH; c++) begin
      chk("rst_count", 32'(count_of(c)), 0);
      chk("rst_empty_n", 32'(if_empty_n[c]), 0);
      chk("rst_full_n", 32'(if_full_n[c]), 1);
      chk("rst_af", 32'(if_almost_full[c]), 0);
    end
    // Push driven while reset is still high, released before the edge:
    // the first edge after release must accept it.
    step(2'b01, 2'b01, 2'b00, 2'b00, 8'h11, 8'h00);
    reset = 1'b0;
    step(2'b01, 2'b01, 2'b00, 2'b00, 8'h22, 8'h00);
    step(2'b01, 2'b01, 2'b00, 2'b00, 8'h33, 8'h00);
    idle();
    chk("dir_dout0_11", 32'(dout_of(0)), 32'h11);
    chk("dir_count0_3", 32'(count_of(0)), 3);
    chk("dir_ch1_empty", 32'(if_empty_n[1]), 0);

    // Fill channel 1, then an ignored push while full.
    for (int i = 0; i < DEPTH; i++) step(2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'(8'hA0 + i));
    step(2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h55);
    idle();
    chk("dir_full_n1", 32'(if_full_n[1]), 0);
    chk("dir_count1_4", 32'(count_of(1)), 4);
    chk("dir_af1", 32'(if_almost_full[1]), 1);
    chk("dir_dout1_a0", 32'(dout_of(1)), 32'hA0);

    // Channel 0 at count 2, then simultaneous push/pop.
    step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h00);
    step(2'b01, 2'b01, 2'b01, 2'b01, 8'hAA, 8'h00);
    idle();
    chk("dir_pp_count0", 32'(count_of(0)), 2);
    chk("dir_pp_dout0", 32'(dout_of(0)), 32'h33);
    step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h00);
    step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h00);
    // Pop on empty channel 0 must be ignored.
    step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h00);
    idle();
    chk("dir_empty_count0", 32'(count_of(0)), 0);
    chk("dir_empty_n0", 32'(if_empty_n[0]), 0);

    // Full channel 1 with push and pop together: only the pop goes through.
    step(2'b10, 2'b10, 2'b10, 2'b10, 8'h00, 8'h66);
    idle();
    chk("dir_fullpp_count1", 32'(count_of(1)), 3);

    // Asynchronous reset in the middle of a pop on channel 0.
    for (int i = 0; i < 3; i++) step(2'b01, 2'b01, 2'b00, 2'b00, 8'(8'h40 + i), 8'h00);
    @(negedge clk); #1;
    if_write_ce = '0; if_write = '0; if_read_ce = 2'b01; if_read = 2'b01;
    #1 reset = 1'b1;
    #1;
    chk("arst_count0", 32'(count_of(0)), 0);
    chk("arst_empty_n0", 32'(if_empty_n[0]), 0);
    chk("arst_full_n0", 32'(if_full_n[0]), 1);
    chk("arst_af0", 32'(if_almost_full[0]), 0);
    chk("arst_count1", 32'(count_of(1)), 0);
    for (int c = 0; c < NCH; c++) begin mq[c].delete(); exp_q[c].delete(); end
    step(2'b01, 2'b01, 2'b00, 2'b00, 8'h77, 8'h00);
    reset = 1'b0;
    idle();
    chk("arst_dout0_77", 32'(dout_of(0)), 32'h77);

    // Random traffic with drifting write/read bias to visit full and empty.
    for (int i = 0; i < 10000; i++) begin
      logic [NCH-1:0] wce, wr, rce, rd;
      int wp = ((i / 500) % 2 == 0) ? 70 : 30;
      for (int c = 0; c < NCH; c++) begin
        wce[c] = ($urandom_range(0, 7) != 0);
        wr[c]  = ($urandom_range(0, 99) < wp);
        rce[c] = ($urandom_range(0, 7) != 0);
        rd[c]  = ($urandom_range(0, 99) < 100 - wp);
      end
      step(wce, wr, rce, rd, 8'($urandom), 8'($urandom));
    end

    for (int i = 0; i < DEPTH + 2; i++) step('0, '0, '1, '1, '0, '0);
    idle();
    idle();
    for (int c = 0; c < NCH; c++) begin
      chk("drain_sb_empty", 32'(exp_q[c].size()), 0);
      chk("drain_model_empty", 32'(mq[c].size()), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
